// File: rtl/regression_predictor_pkg.sv
// Shared defaults, saturation limits and FSM encoding for the regression predictor.
package regression_predictor_pkg;

  localparam int unsigned DefWidth = 20;
  localparam int unsigned DefFrac  = 10;

  // Largest and smallest representable two's-complement values for a given width.
  function automatic longint sat_hi(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/regression_predictor_if.sv
// Coefficient, sample and prediction signals of the regression predictor.
interface regression_predictor_if
  import regression_predictor_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) ();

  logic             coef_load;
  logic [WIDTH-1:0] b_1_in;
  logic [WIDTH-1:0] b_0_in;
  logic             x_valid;
  logic [WIDTH-1:0] x_data;
  logic             x_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready;
  logic             sat;
  logic [15:0]      count;

  modport master (
    output coef_load, b_1_in, b_0_in, x_valid, x_data, y_ready,
    input  x_ready, y_valid, y_data, sat, count
  );

  modport slave (
    input  coef_load, b_1_in, b_0_in, x_valid, x_data, y_ready,
    output x_ready, y_valid, y_data, sat, count
  );

endinterface

// File: rtl/predictor_pipe.sv
// Two-stage multiply / shift-add-saturate pipeline with valid/ready stall control.
module predictor_pipe
  import regression_predictor_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Frac  = DefFrac
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_fire_i,
  input  logic [Width-1:0] in_data_i,
  input  logic [Width-1:0] b1_i,
  input  logic [Width-1:0] b0_i,
  input  logic             y_ready_i,
  output logic             en1_o,
  output logic             v1_o,
  output logic             v2_o,
  output logic [Width-1:0] y_data_o,
  output logic             sat_evt_o
);

  localparam int unsigned PW = 2 * Width;

  localparam logic signed [PW:0]    SumHi = (PW + 1)'(sat_hi(Width));
  localparam logic signed [PW:0]    SumLo = (PW + 1)'(sat_lo(Width));
  localparam logic [Width-1:0]      YHi   = Width'(sat_hi(Width));
  localparam logic [Width-1:0]      YLo   = Width'(sat_lo(Width));

  logic                 v1_q, v1_d, v2_q, v2_d;
  logic signed [PW-1:0] p_q, p_d;
  logic [Width-1:0]     y_q, y_d;
  logic                 en1, en2;
  logic signed [PW-1:0] x_ext, b1_ext, prod, p_sh;
  logic signed [PW:0]   sum;
  logic                 over, under;
  logic [Width-1:0]     y_sat;

  // Stall chain, full-width product and saturating shift-add.
  always_comb begin
    en2    = ~v2_q | y_ready_i;
    en1    = ~v1_q | en2;
    x_ext  = $signed({{Width{in_data_i[Width-1]}}, in_data_i});
    b1_ext = $signed({{Width{b1_i[Width-1]}}, b1_i});
    prod   = x_ext * b1_ext;
    p_sh   = p_q >>> Frac;
    sum    = $signed({p_sh[PW-1], p_sh}) + $signed({{(PW + 1 - Width){b0_i[Width-1]}}, b0_i});
    over   = sum > SumHi;
    under  = sum < SumLo;
    if (over) begin
      y_sat = YHi;
    end else if (under) begin
      y_sat = YLo;
    end else begin
      y_sat = sum[Width-1:0];
    end
  end

  // Next-state for both stages; a stage only moves when its enable allows it.
  always_comb begin
    v1_d      = v1_q;
    p_d       = p_q;
    v2_d      = v2_q;
    y_d       = y_q;
    sat_evt_o = 1'b0;
    if (en1) begin
      v1_d = in_fire_i;
      if (in_fire_i) begin
        p_d = prod;
      end
    end
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        y_d       = y_sat;
        sat_evt_o = over | under;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      p_q  <= '0;
      v2_q <= 1'b0;
      y_q  <= '0;
    end else begin
      v1_q <= v1_d;
      p_q  <= p_d;
      v2_q <= v2_d;
      y_q  <= y_d;
    end
  end

  assign en1_o    = en1;
  assign v1_o     = v1_q;
  assign v2_o     = v2_q;
  assign y_data_o = y_q;

endmodule

// File: rtl/regression_predictor.sv
// Streaming y = b_0 + b_1*x predictor with safe coefficient switching.
module regression_predictor
  import regression_predictor_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned FRAC  = DefFrac
) (
  input logic                   clk,
  input logic                   rst,
  regression_predictor_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] b1_q, b1_d, b0_q, b0_d;
  logic [WIDTH-1:0] sh_b1_q, sh_b1_d, sh_b0_q, sh_b0_d;
  logic             sat_q, sat_d;
  logic [15:0]      count_q, count_d;
  logic             clear;
  logic             en1, v1, v2, sat_evt, empty, x_ready, x_fire, y_fire;
  logic [WIDTH-1:0] y_data;

  assign empty   = ~v1 & ~v2;
  assign x_ready = (state_q == StRun) & en1;
  assign x_fire  = bus.x_valid & x_ready;
  assign y_fire  = v2 & bus.y_ready;

  // Coefficient FSM: load directly when the pipe is empty, else park in shadow and drain.
  always_comb begin
    state_d = state_q;
    b1_d    = b1_q;
    b0_d    = b0_q;
    sh_b1_d = sh_b1_q;
    sh_b0_d = sh_b0_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.coef_load) begin
          b1_d    = bus.b_1_in;
          b0_d    = bus.b_0_in;
          clear   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.coef_load) begin
          if (empty) begin
            b1_d  = bus.b_1_in;
            b0_d  = bus.b_0_in;
            clear = 1'b1;
          end else begin
            sh_b1_d = bus.b_1_in;
            sh_b0_d = bus.b_0_in;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (bus.coef_load) begin
          sh_b1_d = bus.b_1_in;
          sh_b0_d = bus.b_0_in;
        end
        if (empty) begin
          // A load landing on the exit cycle is the newest value.
          b1_d    = bus.coef_load ? bus.b_1_in : sh_b1_q;
          b0_d    = bus.coef_load ? bus.b_0_in : sh_b0_q;
          clear   = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky saturation flag and handshake counter; a coefficient switch clears both.
  always_comb begin
    sat_d   = clear ? 1'b0 : (sat_q | sat_evt);
    count_d = clear ? 16'd0 : (count_q + 16'(y_fire));
  end

  // Control and coefficient state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      b1_q    <= '0;
      b0_q    <= '0;
      sh_b1_q <= '0;
      sh_b0_q <= '0;
      sat_q   <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      b1_q    <= b1_d;
      b0_q    <= b0_d;
      sh_b1_q <= sh_b1_d;
      sh_b0_q <= sh_b0_d;
      sat_q   <= sat_d;
      count_q <= count_d;
    end
  end

  // Stage 1 multiplies by b1_d so a sample accepted on a direct-load cycle uses the new set.
  predictor_pipe #(
    .Width(WIDTH),
    .Frac (FRAC)
  ) u_pipe (
    .clk_i    (clk),
    .rst_ni   (rst),
    .in_fire_i(x_fire),
    .in_data_i(bus.x_data),
    .b1_i     (b1_d),
    .b0_i     (b0_q),
    .y_ready_i(bus.y_ready),
    .en1_o    (en1),
    .v1_o     (v1),
    .v2_o     (v2),
    .y_data_o (y_data),
    .sat_evt_o(sat_evt)
  );

  assign bus.x_ready = x_ready;
  assign bus.y_valid = v2;
  assign bus.y_data  = y_data;
  assign bus.sat     = sat_q;
  assign bus.count   = count_q;

endmodule

// File: tb/tb_regression_predictor.sv
// Randomized and directed bench for regression_predictor against a queue-based reference.
module tb_regression_predictor;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regression_predictor_if #(.WIDTH(20)) bus ();

  regression_predictor #(
    .WIDTH(20),
    .FRAC (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] y;
    int          ep;
  } entry_t;

  entry_t      exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          epoch = 0;
  int          cnt_model = 0;
  bit          sat_model = 1'b0;
  logic [19:0] m_b1 = '0;
  logic [19:0] m_b0 = '0;
  logic [19:0] last_y = '0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // y = floor(x*b1 / 2^10) + b0, clamped to the 20-bit signed range.
  function automatic logic [19:0] ref_y(input logic [19:0] x, input logic [19:0] b1,
                                        input logic [19:0] b0, output bit s);
    longint xs = longint'($signed(x));
    longint bs = longint'($signed(b1));
    longint cs = longint'($signed(b0));
    longint r  = ((xs * bs) >>> 10) + cs;
    s = 1'b0;
    if (r > 524287) begin
      r = 524287;
      s = 1'b1;
    end else if (r < -524288) begin
      r = -524288;
      s = 1'b1;
    end
    return 20'(r);
  endfunction

  // Scoreboard: inputs are stable from posedge+1 until the next posedge.
  always @(negedge clk) begin
    entry_t e;
    bit     s;
    if (rst) begin
      if (bus.x_valid && bus.x_ready) begin
        e.y  = ref_y(bus.x_data, m_b1, m_b0, s);
        e.ep = epoch;
        if (s) sat_model = 1'b1;
        exp_q.push_back(e);
      end
      if (bus.y_valid && bus.y_ready) begin
        last_y = bus.y_data;
        if (exp_q.size() == 0) begin
          check_eq("y_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("y_data", bus.y_data, e.y);
          if (e.ep == epoch) cnt_model++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coef(input logic [19:0] b1, input logic [19:0] b0);
    bus.x_valid   = 1'b0;
    bus.coef_load = 1'b1;
    bus.b_1_in    = b1;
    bus.b_0_in    = b0;
    m_b1          = b1;
    m_b0          = b0;
    epoch++;
    cnt_model     = 0;
    sat_model     = 1'b0;
    step();
    bus.coef_load = 1'b0;
  endtask

  task automatic drive_x(input logic [19:0] x);
    bit acc = 1'b0;
    bus.x_valid = 1'b1;
    bus.x_data  = x;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = bus.x_ready;
      step();
    end
    bus.x_valid = 1'b0;
    if (!acc) check_eq("x_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    bus.y_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      done = (exp_q.size() == 0) && !bus.y_valid;
    end
    if (!done) check_eq("drain_timeout", 0, 1);
    step();
    step();
  endtask

  initial begin
    int          nacc;
    bit          a;
    logic [19:0] rb1, rb0;

    bus.coef_load = 1'b0;
    bus.b_1_in    = '0;
    bus.b_0_in    = '0;
    bus.x_valid   = 1'b0;
    bus.x_data    = '0;
    bus.y_ready   = 1'b0;

    // Reset values.
    #12;
    check_eq("rst_x_ready", bus.x_ready, 0);
    check_eq("rst_y_valid", bus.y_valid, 0);
    check_eq("rst_y_data", bus.y_data, 0);
    check_eq("rst_sat", bus.sat, 0);
    check_eq("rst_count", bus.count, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    check_eq("idle_x_ready", bus.x_ready, 0);

    // Basic 2.0*3.0 + 1.0 with latency check.
    coef(20'h00800, 20'h00400);
    bus.y_ready = 1'b1;
    drive_x(20'h00C00);
    @(negedge clk);
    check_eq("lat_y_valid_early", bus.y_valid, 0);
    @(negedge clk);
    check_eq("lat_y_valid", bus.y_valid, 1);
    check_eq("basic_y", bus.y_data, 20'h01C00);
    wait_idle();
    check_eq("basic_count", bus.count, 1);

    // Negative slope.
    coef(20'hFFC00, 20'h00000);
    drive_x(20'h00800);
    wait_idle();
    check_eq("neg_y", last_y, 20'hFF800);
    check_eq("neg_sat", bus.sat, 0);

    // Saturation both ways, cleared by a reload.
    coef(20'h00800, 20'h00000);
    drive_x(20'h40000);
    wait_idle();
    check_eq("sat_hi_y", last_y, 20'h7FFFF);
    check_eq("sat_hi_flag", bus.sat, 1);
    drive_x(20'hC0000);
    wait_idle();
    check_eq("sat_lo_y", last_y, 20'h80000);
    coef(20'h00800, 20'h00000);
    check_eq("sat_cleared", bus.sat, 0);

    // Backpressure: five beats 1..5 with consumer stalled.
    coef(20'h00800, 20'h00400);
    bus.y_ready = 1'b0;
    bus.x_valid = 1'b1;
    bus.x_data  = 20'h00400;
    nacc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      a = bus.x_ready;
      step();
      if (a) begin
        nacc++;
        bus.x_data = 20'((nacc + 1) << 10);
      end
    end
    check_eq("bp_accepts", nacc, 2);
    check_eq("bp_x_ready", bus.x_ready, 0);
    bus.y_ready = 1'b1;
    for (int c = 0; c < 50 && nacc < 5; c++) begin
      @(negedge clk);
      a = bus.x_ready;
      step();
      if (a) begin
        nacc++;
        bus.x_data = 20'((nacc + 1) << 10);
      end
    end
    bus.x_valid = 1'b0;
    wait_idle();
    check_eq("bp_count", bus.count, 5);
    check_eq("bp_last_y", last_y, 20'h02C00);

    // Coefficient switch with two samples in flight; second load in DRAIN wins.
    coef(20'h00800, 20'h00400);
    bus.y_ready = 1'b0;
    drive_x(20'h00400);
    drive_x(20'h00800);
    check_eq("mid_full", bus.y_valid, 1);
    coef(20'h00C00, 20'h00000);
    check_eq("drain_x_ready", bus.x_ready, 0);
    coef(20'h00400, 20'h00800);
    check_eq("drain_x_ready2", bus.x_ready, 0);
    wait_idle();
    check_eq("mid_old_y", last_y, 20'h01400);
    check_eq("mid_count_clear", bus.count, 0);
    check_eq("mid_x_ready", bus.x_ready, 1);
    drive_x(20'h00800);
    wait_idle();
    check_eq("mid_new_y", last_y, 20'h01000);
    check_eq("mid_count", bus.count, 1);

    // Reset with both stages full.
    coef(20'h00800, 20'h00000);
    bus.y_ready = 1'b0;
    drive_x(20'h00400);
    drive_x(20'h00800);
    check_eq("rmid_full", bus.y_valid, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    epoch++;
    cnt_model = 0;
    sat_model = 1'b0;
    #1;
    check_eq("rmid_y_valid", bus.y_valid, 0);
    check_eq("rmid_y_data", bus.y_data, 0);
    check_eq("rmid_count", bus.count, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.x_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rmid_need_coef", bus.x_ready, 0);
      step();
    end
    coef(20'h00800, 20'h00000);
    check_eq("rmid_after_coef", bus.x_ready, 1);
    wait_idle();

    // Random traffic with mid-stream coefficient changes.
    for (int blk = 0; blk < 16; blk++) begin
      if (($urandom % 4) == 0) begin
        rb1 = 20'($urandom);
      end else begin
        rb1 = 20'($urandom_range(0, 8191)) - 20'd4096;
      end
      rb0 = 20'($urandom);
      coef(rb1, rb0);
      for (int c = 0; c < 60; c++) begin
        bus.x_valid = ($urandom % 4) != 0;
        bus.x_data  = 20'($urandom);
        bus.y_ready = ($urandom % 3) != 0;
        step();
      end
      bus.x_valid = 1'b0;
      if ((blk % 4) == 3) begin
        wait_idle();
        check_eq("rnd_count", bus.count, cnt_model);
        check_eq("rnd_sat", bus.sat, sat_model);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regression_predictor.md
REGRESSION_PREDICTOR -- requirements
Module: regression_predictor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, setting the data and coefficient width.
REQ-002 The block SHALL have parameter FRAC, default 10, setting the fractional bit count; all data is two's-complement fixed point with FRAC fractional bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 coef_load  input  1  single-cycle pulse that latches b_1_in/b_0_in; driven by the regression engine's ready.
REQ-006 b_1_in  input  WIDTH  slope coefficient.
REQ-007 b_0_in  input  WIDTH  intercept coefficient.
REQ-008 x_valid  input  1  an x sample is offered.
REQ-009 x_data  input  WIDTH  x sample.
REQ-010 x_ready  output  1  the block accepts x this cycle.
REQ-011 y_valid  output  1  a prediction is offered.
REQ-012 y_data  output  WIDTH  prediction y = b_0 + b_1*x.
REQ-013 y_ready  input  1  the consumer accepts y this cycle.
REQ-014 sat  output  1  sticky flag; a result has saturated since the last coefficient load.
REQ-015 count  output  16  number of y handshakes since the last coefficient load.

Function
REQ-016 The FSM SHALL have three states: IDLE (no coefficients), RUN, and DRAIN.
REQ-017 IDLE, coef_load: latch coefficients into the active registers, clear sat and count, go to RUN; x_ready SHALL be 0 in IDLE.
REQ-018 RUN, coef_load, both pipeline stages empty: latch directly, clear sat and count, stay in RUN.
REQ-019 RUN, coef_load, either stage valid: capture coefficients into shadow registers and go to DRAIN.
REQ-020 In DRAIN, x_ready SHALL be 0 and in-flight results SHALL complete using the old coefficients.
REQ-021 DRAIN exit: when both stages are empty, copy shadow to active, clear sat and count, and go to RUN.
REQ-022 A coef_load during DRAIN SHALL overwrite the shadow registers (last value wins).
REQ-023 Stage 1 SHALL register p = x_data*b_1 as a full 2*WIDTH signed product, with valid bit v1.
REQ-024 Stage 2 SHALL register y = sat((p >>> FRAC) + sign-extended b_0), with valid bit v2; y_valid = v2.
REQ-025 Stall logic SHALL be: en2 = !v2 | y_ready; en1 = !v1 | en2; x_ready = (state==RUN) & en1.
REQ-026 Accept x on x_valid & x_ready; latency is 2 cycles to y_valid with no stall; throughput is 1 sample per cycle.
REQ-027 Saturation SHALL clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1), and set sat in the same cycle the stage-2 register loads.
REQ-028 count SHALL increment on each y_valid & y_ready handshake and wrap from 0xFFFF to 0.
REQ-029 Samples SHALL never be dropped, duplicated or reordered under any y_ready pattern.
REQ-030 If the coefficient clear and a handshake occur in the same cycle, the clear SHALL win and count = 0.

Reset
REQ-031 On rst low, asynchronously: state = IDLE; v1 = v2 = 0; all data, coefficient and shadow registers = 0; sat = 0; count = 0.
REQ-032 Output values under reset SHALL be x_ready = 0, y_valid = 0 and y_data = 0.
REQ-033 Reset asserted mid-stream SHALL discard all in-flight samples; after release, the block SHALL require a new coef_load.

Structure
REQ-034 A shared package SHALL hold the WIDTH/FRAC defaults, the saturation limit constants, and the FSM state encoding (IDLE, RUN, DRAIN).
REQ-035 The arithmetic pipeline (two stages plus saturation) SHALL be one sub-module, predictor_pipe; the FSM, shadow registers, sat and count stay in the top level.

Verification
REQ-036 Basic: coef_load with b_1=0x00800 (2.0), b_0=0x00400 (1.0); x=0x00C00 (3.0), y_ready=1 -> y_data=0x01C00 (7.0) 2 cycles after accept; count=1.
REQ-037 Negative: b_1=0xFFC00 (-1.0), b_0=0; x=0x00800 -> y_data=0xFF800 (-2.0); sat=0.
REQ-038 Saturation: b_1=0x00800, b_0=0; x=0x40000 -> y_data=0x7FFFF and sat=1; x=0xC0000 -> y_data=0x80000; a following coef_load clears sat.
REQ-039 Backpressure: 5 back-to-back x beats (1..5 in Q10.10) with y_ready held 0 -> x_ready drops after 2 accepts; release y_ready -> outputs 2b_1+b_0 ... in order, none lost; count=5.
REQ-040 Coefficients mid-stream: 2 samples in flight, then coef_load -> DRAIN, x_ready=0, both samples use old coefficients; new coefficients apply to the next accepted x; count=0 after the switch.
REQ-041 Reset mid-stream: rst low with v1=v2=1 -> y_valid=0 immediately; after release, x_ready=0 until coef_load.
